// File: rtl/divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : divider_arbiter
// Purpose  : Round-robin front end that shares one iterative divider among
//            NUM_REQ requesters. One division is in flight at a time;
//            divide-by-zero is answered locally without touching the divider.
//            Results come back on shared quotient/remainder/error buses,
//            qualified by a one-hot response strobe.
// Options  : DIV_ARB_TIMEOUT_EN - adds a WAIT watchdog of TIMEOUT_CYCLES and a
//            DRAIN state that discards late divider results.
// Revision : 1.0 - initial release
// ============================================================================
module divider_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0] divisor_in,
    output logic [NUM_REQ-1:0]       req_ack_out,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         quotient_out,
    output logic [WIDTH-1:0]         remainder_out,
    output logic                     error_out,
    output logic                     busy_out,
    output logic [WIDTH-1:0]         div_dividend_out,
    output logic [WIDTH-1:0]         div_divisor_out,
    output logic                     div_valid_out,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    input  logic                     div_valid_in,
    input  logic                     div_error_in,
    input  logic                     div_busy_in
);

    // Width of a requester index; NUM_REQ is at least 2.
    localparam int C_IDX_W = $clog2(NUM_REQ);

    // State encoding. DRAIN only exists when the watchdog is built in.
    localparam logic [2:0] C_ST_IDLE    = 3'd0;
    localparam logic [2:0] C_ST_ISSUE   = 3'd1;
    localparam logic [2:0] C_ST_WAIT    = 3'd2;
    localparam logic [2:0] C_ST_RESPOND = 3'd3;
`ifdef DIV_ARB_TIMEOUT_EN
    localparam logic [2:0] C_ST_DRAIN   = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;

    logic [C_IDX_W-1:0] r_last_grant;
    logic [C_IDX_W-1:0] w_grant_idx;
    logic [C_IDX_W-1:0] w_cand_idx;
    int                 w_cand;
    logic               w_found;
    logic               w_grant_en;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [NUM_REQ-1:0] r_ack;

    logic [WIDTH-1:0]   w_sel_dividend;
    logic [WIDTH-1:0]   w_sel_divisor;
    logic [WIDTH-1:0]   r_div_dividend;
    logic [WIDTH-1:0]   r_div_divisor;
    logic               r_dbz;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_error;

    logic               w_div_valid;
    logic [NUM_REQ-1:0] w_resp_valid;
    logic               w_busy;
    logic               w_timeout;

    // ------------------------------------------------------------------
    // Round-robin search: the first requesting index after last_grant,
    // wrapping modulo NUM_REQ. Subtraction instead of % keeps it cheap
    // for non power-of-two NUM_REQ.
    // ------------------------------------------------------------------
    // Priority search starting one past the previous winner.
    always_comb begin
        w_grant_idx = r_last_grant;
        w_found     = 1'b0;
        w_cand      = 0;
        w_cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(r_last_grant) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = C_IDX_W'(w_cand);
            if (!w_found && req_valid_in[w_cand_idx]) begin
                w_grant_idx = w_cand_idx;
                w_found     = 1'b1;
            end
        end
    end

    // One-hot form of the winning index.
    always_comb begin
        w_grant_oh              = '0;
        w_grant_oh[w_grant_idx] = 1'b1;
    end

    assign w_grant_en     = (r_state == C_ST_IDLE) && w_found;
    assign w_sel_dividend = dividend_in[int'(w_grant_idx)*WIDTH +: WIDTH];
    assign w_sel_divisor  = divisor_in[int'(w_grant_idx)*WIDTH +: WIDTH];

    // ------------------------------------------------------------------
    // Optional WAIT watchdog
    // ------------------------------------------------------------------
`ifdef DIV_ARB_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_TO_W-1:0] r_wait_cnt;
    logic              r_timed_out;

    // Counts cycles spent in WAIT; the last count without an answer fires.
    assign w_timeout = (r_state == C_ST_WAIT) && !div_valid_in &&
                       (r_wait_cnt == C_TO_W'(TIMEOUT_CYCLES - 1));

    // WAIT cycle counter, restarted on every other state.
    always_ff @(posedge clk_in) begin
        if (rst_in || (r_state != C_ST_WAIT)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Remembers that the current response came from the watchdog, so the
    // FSM drains the divider before the next grant.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_timed_out <= 1'b0;
        end else if (w_timeout) begin
            r_timed_out <= 1'b1;
        end else if (w_grant_en) begin
            r_timed_out <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;

    // Divider busy and the watchdog limit have no function without the
    // watchdog; tie them off here.
    logic w_unused_timeout;
    assign w_unused_timeout = div_busy_in & (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode. A divide-by-zero grant still passes
    // through ISSUE (with the divider strobe suppressed) so that the ack
    // and the response land on separate cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_div_valid  = 1'b0;
        w_resp_valid = '0;
        w_busy       = (r_state != C_ST_IDLE);
        case (r_state)
            C_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = C_ST_ISSUE;
                end
            end
            C_ST_ISSUE: begin
                w_div_valid = !r_dbz;
                w_state_nxt = r_dbz ? C_ST_RESPOND : C_ST_WAIT;
            end
            C_ST_WAIT: begin
                if (div_valid_in || w_timeout) begin
                    w_state_nxt = C_ST_RESPOND;
                end
            end
            C_ST_RESPOND: begin
                w_resp_valid = r_grant_oh;
`ifdef DIV_ARB_TIMEOUT_EN
                w_state_nxt  = r_timed_out ? C_ST_DRAIN : C_ST_IDLE;
`else
                w_state_nxt  = C_ST_IDLE;
`endif
            end
`ifdef DIV_ARB_TIMEOUT_EN
            C_ST_DRAIN: begin
                // The abandoned division must finish before the divider is
                // reused; its result is simply not captured.
                if (!div_busy_in && !div_valid_in) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Grant capture, ack pulse and result registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_last_grant   <= C_IDX_W'(NUM_REQ - 1);
            r_grant_oh     <= '0;
            r_ack          <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_dbz          <= 1'b0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_error        <= 1'b0;
        end else begin
            r_ack <= '0;

            if (w_grant_en) begin
                r_ack          <= w_grant_oh;
                r_grant_oh     <= w_grant_oh;
                r_last_grant   <= w_grant_idx;
                r_div_dividend <= w_sel_dividend;
                r_div_divisor  <= w_sel_divisor;
                r_dbz          <= (w_sel_divisor == '0);
            end

            // Results are loaded on the transition into RESPOND so the
            // shared buses change only together with a response.
            if ((r_state == C_ST_ISSUE) && r_dbz) begin
                r_quotient  <= '0;
                r_remainder <= r_div_dividend;
                r_error     <= 1'b1;
            end else if ((r_state == C_ST_WAIT) && div_valid_in) begin
                r_quotient  <= div_quotient_in;
                r_remainder <= div_remainder_in;
                r_error     <= div_error_in;
            end else if (w_timeout) begin
                r_quotient  <= '0;
                r_remainder <= '0;
                r_error     <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ack_out      = r_ack;
    assign resp_valid_out   = w_resp_valid;
    assign quotient_out     = r_quotient;
    assign remainder_out    = r_remainder;
    assign error_out        = r_error;
    assign busy_out         = w_busy;
    assign div_dividend_out = r_div_dividend;
    assign div_divisor_out  = r_div_divisor;
    assign div_valid_out    = w_div_valid;

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_arbiter
// Purpose  : Self-checking bench for divider_arbiter. Stimulus pushes the
//            expected acks/responses into queues; a monitor pops and compares
//            whenever the DUT strobes. A behavioural divider with adjustable
//            latency sits on the divider port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 64;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [NR-1:0]     req_valid_in = '0;
    logic [NR*W-1:0]   dividend_in  = '0;
    logic [NR*W-1:0]   divisor_in   = '0;
    logic [NR-1:0]     req_ack_out;
    logic [NR-1:0]     resp_valid_out;
    logic [W-1:0]      quotient_out;
    logic [W-1:0]      remainder_out;
    logic              error_out;
    logic              busy_out;
    logic [W-1:0]      div_dividend_out;
    logic [W-1:0]      div_divisor_out;
    logic              div_valid_out;
    logic [W-1:0]      div_quotient_in  = '0;
    logic [W-1:0]      div_remainder_in = '0;
    logic              div_valid_in     = 1'b0;
    logic              div_error_in     = 1'b0;
    logic              div_busy_in      = 1'b0;

    divider_arbiter #(
        .NUM_REQ        (NR),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .dividend_in      (dividend_in),
        .divisor_in       (divisor_in),
        .req_ack_out      (req_ack_out),
        .resp_valid_out   (resp_valid_out),
        .quotient_out     (quotient_out),
        .remainder_out    (remainder_out),
        .error_out        (error_out),
        .busy_out         (busy_out),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_valid_out    (div_valid_out),
        .div_quotient_in  (div_quotient_in),
        .div_remainder_in (div_remainder_in),
        .div_valid_in     (div_valid_in),
        .div_error_in     (div_error_in),
        .div_busy_in      (div_busy_in)
    );

    always #5 clk_in = ~clk_in;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct {
        int         idx;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic       err;
        int         lat;   // cycles from ack to response
    } resp_t;

    resp_t exp_resp[$];
    int    exp_ack[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    ack_cyc[NR];
    int    div_pulses = 0;
    int    div_lat    = 4;
    bit    model_hang = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural divider: answers div_lat cycles after the issue strobe,
    // or stays busy indefinitely while model_hang is set.
    // ------------------------------------------------------------------
    logic [W-1:0] m_a, m_b;
    int           m_cnt;
    bit           m_hang_txn;

    always @(posedge clk_in) begin
        div_valid_in <= 1'b0;
        if (rst_in) begin
            div_busy_in <= 1'b0;
            m_cnt       <= 0;
            m_hang_txn  <= 1'b0;
        end else if (div_valid_out) begin
            m_a         <= div_dividend_out;
            m_b         <= div_divisor_out;
            div_busy_in <= 1'b1;
            m_cnt       <= div_lat - 1;
            m_hang_txn  <= model_hang;
        end else if (div_busy_in) begin
            if (m_hang_txn) begin
                if (!model_hang) div_busy_in <= 1'b0;
            end else if (m_cnt <= 1) begin
                div_valid_in     <= 1'b1;
                div_busy_in      <= 1'b0;
                div_quotient_in  <= (m_b == 0) ? '0 : m_a / m_b;
                div_remainder_in <= (m_b == 0) ? m_a : m_a % m_b;
                div_error_in     <= (m_b == 0);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares every ack and response against the queues.
    // ------------------------------------------------------------------
    int          m_exp_idx;
    resp_t       m_e;
    logic [NR-1:0] m_oh;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (div_valid_out) div_pulses++;
            if (req_ack_out != '0) begin
                for (int i = 0; i < NR; i++) if (req_ack_out[i]) ack_cyc[i] = cyc;
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", req_ack_out, 0);
                end else begin
                    m_exp_idx = exp_ack.pop_front();
                    m_oh = '0;
                    m_oh[m_exp_idx] = 1'b1;
                    chk("ack_grant", req_ack_out, m_oh);
                end
            end
            if (resp_valid_out != '0) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", resp_valid_out, 0);
                end else begin
                    m_e = exp_resp.pop_front();
                    m_oh = '0;
                    m_oh[m_e.idx] = 1'b1;
                    chk("resp_onehot", resp_valid_out, m_oh);
                    chk("resp_quotient", quotient_out, m_e.q);
                    chk("resp_remainder", remainder_out, m_e.r);
                    chk("resp_error", error_out, m_e.err);
                    chk("resp_latency", cyc - ack_cyc[m_e.idx], m_e.lat);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        dividend_in[i*W +: W] = a;
        divisor_in[i*W +: W]  = b;
        req_valid_in[i]       = 1'b1;
    endtask

    task automatic push(input int i, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic err, input int lat);
        resp_t e;
        e.idx = i; e.q = q; e.r = r; e.err = err; e.lat = lat;
        exp_ack.push_back(i);
        exp_resp.push_back(e);
    endtask

    task automatic wait_ack(output int idx);
        idx = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_in);
            if (req_ack_out != '0) begin
                for (int i = 0; i < NR; i++) if (req_ack_out[i]) idx = i;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL ack_wait: no ack within 400 cycles, got none expected one");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_in);
            if (!busy_out && exp_resp.size() == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL idle_wait: busy=%0d pending=%0d expected idle with none pending",
                 busy_out, exp_resp.size());
    endtask

    task automatic wait_resp_drained();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk_in);
            if (exp_resp.size() == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL resp_wait: pending=%0d expected 0", exp_resp.size());
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},       req_ack_out,      0);
        chk({tag, "_resp"},      resp_valid_out,   0);
        chk({tag, "_quotient"},  quotient_out,     0);
        chk({tag, "_remainder"}, remainder_out,    0);
        chk({tag, "_error"},     error_out,        0);
        chk({tag, "_busy"},      busy_out,         0);
        chk({tag, "_div_valid"}, div_valid_out,    0);
        chk({tag, "_div_a"},     div_dividend_out, 0);
        chk({tag, "_div_b"},     div_divisor_out,  0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int idx;
    int pulses_before;
    int n_ack;

    initial begin
        repeat (2) @(negedge clk_in);
        do_reset();
        chk_reset_outputs("reset");

        // Single request 1000/8 on requester 1.
        div_lat = 4;
        @(negedge clk_in);
        set_req(1, 1000, 8);
        push(1, 125, 0, 1'b0, div_lat + 1);
        @(negedge clk_in);
        chk("t1_ack_next_cycle", req_ack_out, 4'b0010);
        chk("t1_div_valid", div_valid_out, 1);
        chk("t1_div_a", div_dividend_out, 1000);
        chk("t1_div_b", div_divisor_out, 8);
        chk("t1_busy", busy_out, 1);
        req_valid_in[1] = 1'b0;
        wait_idle();

        // All four at once from reset: strict order 0,1,2,3.
        do_reset();
        @(negedge clk_in);
        set_req(0, 100, 7);
        set_req(1, 200, 9);
        set_req(2, 300, 11);
        set_req(3, 400, 13);
        push(0, 14, 2,  1'b0, div_lat + 1);
        push(1, 22, 2,  1'b0, div_lat + 1);
        push(2, 27, 3,  1'b0, div_lat + 1);
        push(3, 30, 10, 1'b0, div_lat + 1);
        for (int n = 0; n < 4; n++) begin
            wait_ack(idx);
            if (idx >= 0) req_valid_in[idx] = 1'b0;
        end
        wait_idle();

        // Fairness: 0 and 2 held for six transactions alternate.
        @(negedge clk_in);
        set_req(0, 61, 6);
        set_req(2, 77, 8);
        for (int n = 0; n < 3; n++) begin
            push(0, 10, 1, 1'b0, div_lat + 1);
            push(2, 9,  5, 1'b0, div_lat + 1);
        end
        for (int n = 0; n < 6; n++) wait_ack(idx);
        req_valid_in[0] = 1'b0;
        req_valid_in[2] = 1'b0;
        wait_idle();

        // Divide-by-zero on requester 3: answered without the divider.
        pulses_before = div_pulses;
        @(negedge clk_in);
        set_req(3, 55, 0);
        push(3, 0, 55, 1'b1, 1);
        @(negedge clk_in);
        chk("t4_ack_next_cycle", req_ack_out, 4'b1000);
        req_valid_in[3] = 1'b0;
        wait_idle();
        chk("t4_no_div_pulse", div_pulses, pulses_before);

        // Reset three cycles after ISSUE abandons the transaction.
        div_lat = 10;
        @(negedge clk_in);
        set_req(0, 50, 5);
        exp_ack.push_back(0);
        @(negedge clk_in);
        req_valid_in[0] = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk_reset_outputs("wait_reset");
        rst_in = 1'b0;
        repeat (15) @(negedge clk_in);
        chk("t5_no_pending_ack", exp_ack.size(), 0);
        div_lat = 4;
        set_req(0, 9, 3);
        push(0, 3, 0, 1'b0, div_lat + 1);
        wait_ack(idx);
        req_valid_in[0] = 1'b0;
        wait_idle();

`ifdef DIV_ARB_TIMEOUT_EN
        // Watchdog: divider never answers and stays busy.
        model_hang = 1'b1;
        @(negedge clk_in);
        set_req(1, 5, 1);
        push(1, 0, 0, 1'b1, TO + 1);
        wait_ack(idx);
        req_valid_in[1] = 1'b0;
        wait_resp_drained();
        set_req(2, 9, 3);
        n_ack = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_in);
            if (req_ack_out != '0) n_ack++;
        end
        chk("t6_no_grant_while_busy", n_ack, 0);
        push(2, 3, 0, 1'b0, div_lat + 1);
        model_hang = 1'b0;
        wait_ack(idx);
        req_valid_in[2] = 1'b0;
        wait_idle();
`endif

        repeat (5) @(negedge clk_in);
        chk("queues_empty", exp_ack.size() + exp_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected one");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
